// File: rtl/handshake_sched_pkg.sv
// Shared helpers for round-robin handshake schedulers: index-width
// calculation and the rotate-and-priority search used by the arbiter.
package handshake_sched_pkg;

  localparam int MAX_REQ   = 16;
  localparam int MAX_IDX_W = 4;

  typedef struct packed {
    logic                 found;
    logic [MAX_IDX_W-1:0] idx;
  } rr_pick_t;

  function automatic int calc_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Walk offsets from the highest down so the smallest offset from ptr
  // is the last assignment and therefore the winner.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                       input int n, input int ptr);
    rr_pick_t res;
    int       j;
    res = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < n) begin
        j = ptr + k;
        if (j >= n) j = j - n;
        if (req[j[MAX_IDX_W-1:0]]) begin
          res.found = 1'b1;
          res.idx   = j[MAX_IDX_W-1:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/handshake_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr,
// wrapping; one-hot grant plus binary index, grant gated by en.
module handshake_rr_arbiter
  import handshake_sched_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = calc_idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [MAX_REQ-1:0] req_ext;
  rr_pick_t           pick;

  // NOTE: every signal driven here gets a default before any condition,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req;
    pick           = rr_pick(req_ext, N, int'(ptr));
    gnt_idx        = IW'(pick.idx);
    gnt            = '0;
    for (int i = 0; i < N; i++) begin
      gnt[i] = en & pick.found & (int'(pick.idx) == i);
    end
  end

endmodule

// File: rtl/handshake_constant_sched.sv
// Shared constant source: round-robin grants control tokens into a
// one-entry output slot tagged with the requester index.
// Optional runtime constant load: define HANDSHAKE_CONSTANT_SCHED_CFG_EN.
module handshake_constant_sched
  import handshake_sched_pkg::*;
#(
  parameter int                    NUM_REQ     = 4,
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] CONST_VALUE = '0,
  localparam int                   IDX_W       = calc_idx_w(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    ctrl_valid,
  output logic [NUM_REQ-1:0]    ctrl_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic [IDX_W-1:0]      outs_index,
  output logic                  outs_valid,
  input  logic                  outs_ready
`ifdef HANDSHAKE_CONSTANT_SCHED_CFG_EN
  ,
  input  logic                  cfg_we,
  input  logic [DATA_WIDTH-1:0] cfg_data
`endif
);

  logic                  full_q, full_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] const_q;
  logic [IDX_W-1:0]      gnt_idx;
  logic                  can_take;
  logic                  grant;

  // Grants are suppressed while reset is held so no token is accepted.
  assign can_take = ~full_q | outs_ready;

  handshake_rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IDX_W)
  ) u_arb (
    .req     (ctrl_valid),
    .ptr     (ptr_q),
    .en      (can_take & rst),
    .gnt     (ctrl_ready),
    .gnt_idx (gnt_idx)
  );

  assign grant = |ctrl_ready;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    idx_d  = idx_q;
    ptr_d  = ptr_q;
    if (grant) begin
      full_d = 1'b1;
      data_d = const_q;
      idx_d  = gnt_idx;
      ptr_d  = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
    end else if (outs_ready) begin
      full_d = 1'b0;
    end
  end

  // NOTE: sequential state is written with non-blocking assignments so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      full_q <= 1'b0;
      data_q <= '0;
      idx_q  <= '0;
      ptr_q  <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      idx_q  <= idx_d;
      ptr_q  <= ptr_d;
    end
  end

`ifdef HANDSHAKE_CONSTANT_SCHED_CFG_EN
  // A grant on the same edge as a load captures the old constant.
  always_ff @(posedge clk) begin
    if (!rst) begin
      const_q <= CONST_VALUE;
    end else if (cfg_we) begin
      const_q <= cfg_data;
    end
  end
`else
  assign const_q = CONST_VALUE;
`endif

  assign outs       = data_q;
  assign outs_index = idx_q;
  assign outs_valid = full_q;

endmodule

// File: tb/tb_handshake_constant_sched.sv
// Randomized self-checking bench for handshake_constant_sched against a
// token-level reference model (builds with or without the cfg macro).
module tb_handshake_constant_sched;

  localparam int              NR      = 4;
  localparam int              DW      = 32;
  localparam int              IW      = 2;
  localparam logic [DW-1:0]   CONST_V = 32'h0000_0C0E;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] ctrl_valid;
  logic [NR-1:0] ctrl_ready;
  logic [DW-1:0] outs;
  logic [IW-1:0] outs_index;
  logic          outs_valid;
  logic          outs_ready;
  logic          cfg_we;
  logic [DW-1:0] cfg_data;

  always #5 clk = ~clk;

  handshake_constant_sched #(
    .NUM_REQ     (NR),
    .DATA_WIDTH  (DW),
    .CONST_VALUE (CONST_V)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ctrl_valid (ctrl_valid),
    .ctrl_ready (ctrl_ready),
    .outs       (outs),
    .outs_index (outs_index),
    .outs_valid (outs_valid),
    .outs_ready (outs_ready)
`ifdef HANDSHAKE_CONSTANT_SCHED_CFG_EN
    ,
    .cfg_we     (cfg_we),
    .cfg_data   (cfg_data)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: one-slot buffer, rotating start point, constant.
  bit          m_full  = 1'b0;
  logic [DW-1:0] m_data = '0;
  int          m_idx   = 0;
  int          m_ptr   = 0;
  logic [DW-1:0] m_const = CONST_V;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NR-1:0] v, input int p);
    for (int k = 0; k < NR; k++) begin
      if (v[(p + k) % NR]) return (p + k) % NR;
    end
    return -1;
  endfunction

  task automatic cycle(input logic [NR-1:0] v, input logic ordy,
                       input logic rstv, input logic we,
                       input logic [DW-1:0] cd);
    int            w;
    logic [NR-1:0] exp_rdy;
    @(negedge clk);
    rst        = rstv;
    ctrl_valid = v;
    outs_ready = ordy;
    cfg_we     = we;
    cfg_data   = cd;
    #1;
    w       = pick(v, m_ptr);
    exp_rdy = '0;
    if (rstv && (!m_full || ordy) && w >= 0) exp_rdy[w] = 1'b1;
    check("ctrl_ready", 64'(ctrl_ready), 64'(exp_rdy));
    check("outs_valid", 64'(outs_valid), 64'(m_full));
    check("outs",       64'(outs),       64'(m_data));
    check("outs_index", 64'(outs_index), 64'(m_idx));
    if (!rstv) begin
      m_full = 1'b0; m_data = '0; m_idx = 0; m_ptr = 0; m_const = CONST_V;
    end else begin
      if (exp_rdy != '0) begin
        m_full = 1'b1; m_data = m_const; m_idx = w; m_ptr = (w + 1) % NR;
      end else if (ordy) begin
        m_full = 1'b0;
      end
`ifdef HANDSHAKE_CONSTANT_SCHED_CFG_EN
      if (we) m_const = cd;
`endif
    end
  endtask

  initial begin
    rst = 1'b0; ctrl_valid = '0; outs_ready = 1'b0; cfg_we = 1'b0; cfg_data = '0;
    repeat (2) @(posedge clk);

    // Reset state, then idle.
    cycle(4'b0000, 1'b0, 1'b0, 1'b0, '0);
    cycle(4'b0000, 1'b1, 1'b1, 1'b0, '0);

    // All requesters valid: grants rotate 0,1,2,3 with no bubbles.
    for (int i = 0; i < 8; i++) cycle(4'b1111, 1'b1, 1'b1, 1'b0, '0);
    cycle(4'b0000, 1'b1, 1'b1, 1'b0, '0);
    check("rr_last_index", 64'(outs_index), 64'd3);

    // Backpressure on requester 2, then drain with simultaneous grant.
    for (int i = 0; i < 3; i++) cycle(4'b0100, 1'b0, 1'b1, 1'b0, '0);
    check("stall_index", 64'(outs_index), 64'd2);
    cycle(4'b0100, 1'b1, 1'b1, 1'b0, '0);
    cycle(4'b0000, 1'b1, 1'b1, 1'b0, '0);
    check("no_bubble_valid", 64'(outs_valid), 64'd1);

    // Move ptr to 1, then 1001 must grant 3, 0, 3.
    cycle(4'b0001, 1'b1, 1'b1, 1'b0, '0);
    for (int i = 0; i < 3; i++) cycle(4'b1001, 1'b1, 1'b1, 1'b0, '0);
    cycle(4'b0000, 1'b1, 1'b1, 1'b0, '0);
    check("wrap_last_index", 64'(outs_index), 64'd3);

    // Config load coincident with a grant: old value first, new value next.
    cycle(4'b0010, 1'b1, 1'b1, 1'b1, 32'h0000_00A5);
    cycle(4'b0010, 1'b1, 1'b1, 1'b0, '0);
    check("cfg_same_cycle_old", 64'(outs), 64'(CONST_V));
    cycle(4'b0000, 1'b1, 1'b1, 1'b0, '0);
`ifdef HANDSHAKE_CONSTANT_SCHED_CFG_EN
    check("cfg_next_grant_new", 64'(outs), 64'h0000_00A5);
`else
    check("const_fixed", 64'(outs), 64'(CONST_V));
`endif

    // Reset while holding a token: token dropped, first grant lowest index.
    cycle(4'b0100, 1'b0, 1'b1, 1'b0, '0);
    cycle(4'b1111, 1'b0, 1'b0, 1'b0, '0);
    cycle(4'b0110, 1'b1, 1'b1, 1'b0, '0);
    cycle(4'b0000, 1'b0, 1'b1, 1'b0, '0);
    check("post_reset_grant", 64'(outs_index), 64'd1);

    // Randomized traffic, backpressure, occasional reset and config loads.
    for (int i = 0; i < 400; i++) begin
      cycle(NR'($urandom), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 49) != 0), ($urandom_range(0, 7) == 0),
            DW'($urandom));
    end
    cycle(4'b0000, 1'b1, 1'b1, 1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
